// File: rtl/enemy_hit_ctrl.sv
// Enemy tank controller: bullet/enemy overlap test, explosion and respawn sequencing, kill score.
// Build option: define ENEMY_SCORE_EN to build the saturating 4-digit BCD kill counter on score.
module enemy_hit_ctrl #(
   parameter int         TANK_SIZE      = 32,
   parameter int         BULLET_SIZE    = 8,
   parameter int         EXPLODE_FRAMES = 4,
   parameter int         RESPAWN_FRAMES = 60,
   parameter logic [9:0] SPAWN0_X       = 10'd96,
   parameter logic [9:0] SPAWN1_X       = 10'd304,
   parameter logic [9:0] SPAWN2_X       = 10'd512,
   parameter logic [9:0] SPAWN_Y        = 10'd0
) (
   input  logic        frame_clk,
   input  logic        Reset,
   input  logic        bullet_valid,
   input  logic [9:0]  bullet_x,
   input  logic [9:0]  bullet_y,
   output logic        bullet_kill,
   output logic [9:0]  enemy_x,
   output logic [9:0]  enemy_y,
   output logic        enemy_visible,
   output logic        explode_act,
   output logic [1:0]  explode_frame,
   output logic [15:0] score
);

   typedef enum logic [1:0] {
      ST_ALIVE   = 2'd0,
      ST_EXPLODE = 2'd1,
      ST_DEAD    = 2'd2
   } state_t;

   localparam int PH_W = (EXPLODE_FRAMES > 1) ? $clog2(EXPLODE_FRAMES) : 1;
   localparam int RS_W = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(EXPLODE_FRAMES - 1);
   localparam logic [RS_W-1:0] RS_LAST = RS_W'(RESPAWN_FRAMES - 1);
   localparam logic [10:0]     TANK_W  = 11'(TANK_SIZE);
   localparam logic [10:0]     BUL_W   = 11'(BULLET_SIZE);

   state_t          r_state;
   state_t          w_state_next;
   logic            r_bullet_valid;
   logic [9:0]      r_bullet_x;
   logic [9:0]      r_bullet_y;
   logic [PH_W-1:0] r_phase;
   logic [PH_W-1:0] w_phase_next;
   logic [1:0]      r_frame;
   logic [1:0]      w_frame_next;
   logic [RS_W-1:0] r_dead_cnt;
   logic [RS_W-1:0] w_dead_next;
   logic [1:0]      r_spawn_idx;
   logic [1:0]      w_spawn_next;
   logic [1:0]      w_spawn_adv;
   logic [9:0]      w_spawn_x;
   logic [9:0]      r_enemy_x;
   logic [9:0]      w_enemy_x_next;
   logic [9:0]      r_enemy_y;
   logic [9:0]      w_enemy_y_next;
   logic            r_kill;
   logic            w_kill_next;
   logic            w_hit;
   logic [10:0]     w_bx_ext;
   logic [10:0]     w_by_ext;
   logic [10:0]     w_ex_ext;
   logic [10:0]     w_ey_ext;

   // 11-bit operands so box edge sums never wrap near the 10-bit limit
   assign w_bx_ext = {1'b0, r_bullet_x};
   assign w_by_ext = {1'b0, r_bullet_y};
   assign w_ex_ext = {1'b0, r_enemy_x};
   assign w_ey_ext = {1'b0, r_enemy_y};

   assign w_hit = (r_state == ST_ALIVE) && r_bullet_valid
                  && (w_bx_ext < w_ex_ext + TANK_W) && (w_bx_ext + BUL_W > w_ex_ext)
                  && (w_by_ext < w_ey_ext + TANK_W) && (w_by_ext + BUL_W > w_ey_ext);

   always_comb begin
      w_spawn_adv = (r_spawn_idx == 2'd2) ? 2'd0 : r_spawn_idx + 2'd1;
      case (w_spawn_adv)
         2'd0:    w_spawn_x = SPAWN0_X;
         2'd1:    w_spawn_x = SPAWN1_X;
         default: w_spawn_x = SPAWN2_X;
      endcase
   end

   always_comb begin
      w_state_next   = r_state;
      w_phase_next   = r_phase;
      w_frame_next   = r_frame;
      w_dead_next    = r_dead_cnt;
      w_spawn_next   = r_spawn_idx;
      w_enemy_x_next = r_enemy_x;
      w_enemy_y_next = r_enemy_y;
      w_kill_next    = 1'b0;
      case (r_state)
         ST_ALIVE: begin
            if (w_hit) begin
               w_state_next = ST_EXPLODE;
               w_phase_next = '0;
               w_frame_next = 2'd0;
               w_kill_next  = 1'b1;
            end
         end
         ST_EXPLODE: begin
            if (r_phase == PH_LAST) begin
               w_phase_next = '0;
               w_frame_next = r_frame + 2'd1;
               if (r_frame == 2'd3) begin
                  w_state_next = ST_DEAD;
                  w_dead_next  = '0;
               end
            end else begin
               w_phase_next = r_phase + PH_W'(1);
            end
         end
         ST_DEAD: begin
            if (r_dead_cnt == RS_LAST) begin
               w_state_next   = ST_ALIVE;
               w_dead_next    = '0;
               w_spawn_next   = w_spawn_adv;
               w_enemy_x_next = w_spawn_x;
               w_enemy_y_next = SPAWN_Y;
            end else begin
               w_dead_next = r_dead_cnt + RS_W'(1);
            end
         end
         default: begin
            w_state_next = ST_ALIVE;
         end
      endcase
   end

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         r_state        <= ST_ALIVE;
         r_bullet_valid <= 1'b0;
         r_bullet_x     <= '0;
         r_bullet_y     <= '0;
         r_phase        <= '0;
         r_frame        <= 2'd0;
         r_dead_cnt     <= '0;
         r_spawn_idx    <= 2'd0;
         r_enemy_x      <= SPAWN0_X;
         r_enemy_y      <= SPAWN_Y;
         r_kill         <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_bullet_valid <= bullet_valid;
         r_bullet_x     <= bullet_x;
         r_bullet_y     <= bullet_y;
         r_phase        <= w_phase_next;
         r_frame        <= w_frame_next;
         r_dead_cnt     <= w_dead_next;
         r_spawn_idx    <= w_spawn_next;
         r_enemy_x      <= w_enemy_x_next;
         r_enemy_y      <= w_enemy_y_next;
         r_kill         <= w_kill_next;
      end
   end

   assign bullet_kill   = r_kill;
   assign enemy_x       = r_enemy_x;
   assign enemy_y       = r_enemy_y;
   assign enemy_visible = (r_state == ST_ALIVE);
   assign explode_act   = (r_state == ST_EXPLODE);
   assign explode_frame = r_frame;

`ifdef ENEMY_SCORE_EN
   logic [15:0] r_score;
   logic [15:0] w_score_next;
   logic [3:0]  w_carry;

   // ripple a decimal carry through the four digits; a full 9999 never increments
   assign w_carry[0] = w_hit && (r_score != 16'h9999);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_bcd
         if (gi < 3) begin : g_carry
            assign w_carry[gi+1] = w_carry[gi] && (r_score[gi*4 +: 4] == 4'd9);
         end
         assign w_score_next[gi*4 +: 4] = !w_carry[gi] ? r_score[gi*4 +: 4] :
                                          (r_score[gi*4 +: 4] == 4'd9) ? 4'd0 :
                                          r_score[gi*4 +: 4] + 4'd1;
      end
   endgenerate

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         r_score <= 16'h0000;
      end else begin
         r_score <= w_score_next;
      end
   end

   assign score = r_score;
`else
   assign score = 16'h0000;
`endif

endmodule

// File: tb/tb_enemy_hit_ctrl.sv
// Self-checking bench for enemy_hit_ctrl: vector table with scoreboard, respawn/reset sequences,
// and a fast-timing instance driven through 10000 kills for score saturation.
module tb_enemy_hit_ctrl;

   logic frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   logic        rst, bv;
   logic [9:0]  bx, by;
   logic        kill, vis, xact;
   logic [9:0]  ex, ey;
   logic [1:0]  xfr;
   logic [15:0] score;

   logic        f_rst, f_bv;
   logic [9:0]  f_bx, f_by;
   logic        f_kill, f_vis, f_xact;
   logic [9:0]  f_ex, f_ey;
   logic [1:0]  f_xfr;
   logic [15:0] f_score;

   enemy_hit_ctrl u_dut (
      .frame_clk(frame_clk), .Reset(rst), .bullet_valid(bv), .bullet_x(bx), .bullet_y(by),
      .bullet_kill(kill), .enemy_x(ex), .enemy_y(ey), .enemy_visible(vis),
      .explode_act(xact), .explode_frame(xfr), .score(score)
   );

   enemy_hit_ctrl #(.EXPLODE_FRAMES(1), .RESPAWN_FRAMES(1)) u_fast (
      .frame_clk(frame_clk), .Reset(f_rst), .bullet_valid(f_bv), .bullet_x(f_bx), .bullet_y(f_by),
      .bullet_kill(f_kill), .enemy_x(f_ex), .enemy_y(f_ey), .enemy_visible(f_vis),
      .explode_act(f_xact), .explode_frame(f_xfr), .score(f_score)
   );

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [9:0] x;
      logic [9:0] y;
      logic       v;
      logic       kill;
   } vec_t;

   typedef struct {
      int          idx;
      logic        kill;
      logic [15:0] score;
   } exp_t;

   vec_t vecs[12];
   exp_t sbq[$];
   int   spawn_x[3] = '{96, 304, 512};

   function automatic logic [15:0] exp_score(input int n);
      int m;
      m = (n > 9999) ? 9999 : n;
`ifdef ENEMY_SCORE_EN
      return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
`else
      return (m >= 0) ? 16'h0000 : 16'h0000;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge frame_clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bv  = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   // fire at an enemy whose top-left X is ex0, then wait out explosion and respawn wait
   task automatic do_kill(input int ex0, input int nkills, input int next_x);
      int k;
      bx = 10'(ex0 + 4);
      by = 10'd20;
      bv = 1'b1;
      tick();
      tick();
      check("kill_pulse", 32'(kill), 32'd1);
      check("kill_score", 32'(score), 32'(exp_score(nkills)));
      bv = 1'b0;
      for (k = 0; k < 76; k++) tick();
      check("respawn_x", 32'(ex), 32'(next_x));
      check("respawn_vis", 32'(vis), 32'd1);
      $display("kill at x=%0d -> respawn x=%0d score=%0h", ex0, ex, score);
   endtask

   initial begin
      exp_t e;
      int   kcount;
      int   kills, idx, cyc;

      vecs[0]  = '{10'd100,  10'd20,   1'b1, 1'b1};
      vecs[1]  = '{10'd128,  10'd20,   1'b1, 1'b0};
      vecs[2]  = '{10'd88,   10'd20,   1'b1, 1'b0};
      vecs[3]  = '{10'd89,   10'd20,   1'b1, 1'b1};
      vecs[4]  = '{10'd100,  10'd32,   1'b1, 1'b0};
      vecs[5]  = '{10'd100,  10'd20,   1'b0, 1'b0};
      vecs[6]  = '{10'd127,  10'd31,   1'b1, 1'b1};
      vecs[7]  = '{10'd96,   10'd0,    1'b1, 1'b1};
      vecs[8]  = '{10'd0,    10'd0,    1'b1, 1'b0};
      vecs[9]  = '{10'd1023, 10'd1023, 1'b1, 1'b0};
      vecs[10] = '{10'd120,  10'd24,   1'b1, 1'b1};
      vecs[11] = '{10'd100,  10'd1020, 1'b1, 1'b0};

      rst = 1'b0; bv = 1'b0; bx = '0; by = '0;
      f_rst = 1'b0; f_bv = 1'b0; f_bx = '0; f_by = '0;

      // reset state
      do_reset();
      check("rst_ex", 32'(ex), 32'd96);
      check("rst_ey", 32'(ey), 32'd0);
      check("rst_vis", 32'(vis), 32'd1);
      check("rst_xact", 32'(xact), 32'd0);
      check("rst_xfr", 32'(xfr), 32'd0);
      check("rst_kill", 32'(kill), 32'd0);
      check("rst_score", 32'(score), 32'd0);

      // table vectors: enemy at (96,0), hit is sampled two edges after drive
      for (int i = 0; i < 12; i++) begin
         do_reset();
         bx = vecs[i].x;
         by = vecs[i].y;
         bv = vecs[i].v;
         sbq.push_back('{i, vecs[i].kill, exp_score(vecs[i].kill ? 1 : 0)});
         tick();
         tick();
         e = sbq.pop_front();
         check($sformatf("vec%0d_kill", e.idx), 32'(kill), 32'(e.kill));
         check($sformatf("vec%0d_xact", e.idx), 32'(xact), 32'(e.kill));
         check($sformatf("vec%0d_score", e.idx), 32'(score), 32'(e.score));
         bv = 1'b0;
         tick();
         check($sformatf("vec%0d_pulse_end", e.idx), 32'(kill), 32'd0);
         $display("vec %0d bullet(%0d,%0d) valid=%0d kill=%0d exp=%0d",
                  e.idx, vecs[i].x, vecs[i].y, vecs[i].v, kill, e.kill);
      end

      // explosion phases, dead period and respawn, bullet held on the dead enemy throughout
      do_reset();
      bx = 10'd100; by = 10'd20; bv = 1'b1;
      tick();
      tick();
      check("seq_kill", 32'(kill), 32'd1);
      kcount = 0;
      for (int k = 0; k < 16; k++) begin
         check($sformatf("seq_xact_%0d", k), 32'(xact), 32'd1);
         check($sformatf("seq_xfr_%0d", k), 32'(xfr), 32'(k / 4));
         tick();
         kcount += int'(kill);
      end
      check("seq_dead_xact", 32'(xact), 32'd0);
      check("seq_dead_vis", 32'(vis), 32'd0);
      for (int k = 0; k < 59; k++) begin
         tick();
         kcount += int'(kill);
      end
      check("seq_still_dead", 32'(vis), 32'd0);
      check("seq_no_kill_dead", 32'(kcount), 32'd0);
      check("seq_score_held", 32'(score), 32'(exp_score(1)));
      tick();
      check("seq_respawn_vis", 32'(vis), 32'd1);
      check("seq_respawn_x", 32'(ex), 32'd304);
      check("seq_respawn_y", 32'(ey), 32'd0);
      $display("sequence: respawn at (%0d,%0d) score=%0h", ex, ey, score);
      bv = 1'b0;

      // three kills: respawn order 304, 512, 96
      do_reset();
      do_kill(96, 1, 304);
      do_kill(304, 2, 512);
      do_kill(512, 3, 96);

      // reset in the middle of the explosion
      bx = 10'd100; by = 10'd20; bv = 1'b1;
      tick();
      tick();
      check("mid_kill", 32'(kill), 32'd1);
      bv = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      check("mid_pre_xfr", 32'(xfr), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_vis", 32'(vis), 32'd1);
      check("mid_rst_xact", 32'(xact), 32'd0);
      check("mid_rst_ex", 32'(ex), 32'd96);
      check("mid_rst_xfr", 32'(xfr), 32'd0);
      check("mid_rst_score", 32'(score), 32'd0);
      // explosion restarts from phase 0 with a fresh counter
      bx = 10'd100; bv = 1'b1;
      tick();
      tick();
      bv = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      check("mid_rerun_xfr3", 32'(xfr), 32'd0);
      tick();
      check("mid_rerun_xfr4", 32'(xfr), 32'd1);
      $display("mid-explode reset: x=%0d score=%0h", ex, score);

      // reset on the edge that would sample a hit
      do_reset();
      bx = 10'd100; by = 10'd20; bv = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bv  = 1'b0;
      check("rst_hit_kill", 32'(kill), 32'd0);
      check("rst_hit_vis", 32'(vis), 32'd1);
      check("rst_hit_score", 32'(score), 32'd0);
      tick();
      check("rst_hit_after", 32'(kill), 32'd0);
      $display("reset-vs-hit: kill=%0d score=%0h", kill, score);

      // fast instance: 10000 kills, bullet parked on the next spawn while dead
      f_rst = 1'b1;
      tick();
      f_rst = 1'b0;
      f_bv = 1'b1; f_bx = 10'd100; f_by = 10'd20;
      kills = 0; idx = 0; cyc = 0;
      while (kills < 10000 && cyc < 65000) begin
         tick();
         cyc++;
         if (f_kill) begin
            kills++;
            idx = (idx + 1) % 3;
            f_bx = 10'(spawn_x[idx] + 4);
            if (kills == 9999) check("fast_score_9999", 32'(f_score), 32'(exp_score(9999)));
         end
      end
      f_bv = 1'b0;
      check("fast_kill_count", 32'(kills), 32'd10000);
      for (int k = 0; k < 8; k++) tick();
      check("fast_score_hold", 32'(f_score), 32'(exp_score(10000)));
      $display("fast: %0d kills in %0d cycles score=%0h", kills, cyc, f_score);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
